// File: rtl/riscv_pkg.sv
// Shared RV encoding constants and the immediate-format code used by the decode stage.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_NONE    = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

endpackage

// File: rtl/riscv_imm_decode.sv
// Combinational immediate extraction: instruction word -> sign-extended immediate, format, illegal flag.
module riscv_imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  localparam int SHW = $clog2(XLEN);

  logic [6:0]         opc;
  logic               is_shift;
  logic               sh_word;
  logic signed [31:0] v;

  assign opc      = instr_i[6:0];
  assign is_shift = (instr_i[14:12] == F3_SLL) || (instr_i[14:12] == F3_SRL_SRA);

  always_comb begin
    fmt_o   = FMT_ILLEGAL;
    sh_word = 1'b0;
    if (instr_i[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI, OPC_AUIPC:                        fmt_o = FMT_U;
        OPC_JAL:                                   fmt_o = FMT_J;
        OPC_JALR, OPC_LOAD, OPC_FENCE, OPC_SYSTEM: fmt_o = FMT_I;
        OPC_OPIMM:                                 fmt_o = is_shift ? FMT_SHAMT : FMT_I;
        OPC_STORE:                                 fmt_o = FMT_S;
        OPC_BRANCH:                                fmt_o = FMT_B;
        OPC_OP:                                    fmt_o = FMT_NONE;
        OPC_OPIMM32: begin
          // word ops only exist on RV64; their shifts take a 5-bit shamt
          if (XLEN == 64) begin
            fmt_o   = is_shift ? FMT_SHAMT : FMT_I;
            sh_word = 1'b1;
          end
        end
        default: fmt_o = FMT_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    v     = '0;
    imm_o = '0;
    case (fmt_o)
      FMT_I: v = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: v = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: v = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: v = {instr_i[31:12], 12'b0};
      FMT_J: v = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: v = '0;
    endcase
    if (fmt_o == FMT_SHAMT)
      imm_o = sh_word ? XLEN'(instr_i[24:20]) : XLEN'(instr_i[20 +: SHW]);
    else
      imm_o = XLEN'(v);
  end

  assign illegal_o = (fmt_o == FMT_ILLEGAL);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with a 2-entry skid buffer and synchronous flush.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e          state_q;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill;

  logic [31:0]     skid_instr_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [2:0]      skid_fmt_q;
  logic            skid_ill_q;

  logic acc;
  logic pop;

  riscv_imm_decode #(.XLEN(XLEN)) u_dec (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  // ready is a function of held state, flush and reset only, never of in_valid
  assign in_ready  = !rst && !flush &&
                     (SKID_EN ? (state_q != S_TWO) : ((state_q == S_EMPTY) || out_ready));
  assign out_valid = (state_q != S_EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      out_instr    <= '0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_fmt      <= '0;
      out_illegal  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_ill;
            state_q     <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && !pop) begin
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
            skid_imm_q   <= dec_imm;
            skid_fmt_q   <= dec_fmt;
            skid_ill_q   <= dec_ill;
            state_q      <= S_TWO;
          end else if (acc && pop) begin
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_ill;
          end else if (pop) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            out_instr   <= skid_instr_q;
            out_pc      <= skid_pc_q;
            out_imm     <= skid_imm_q;
            out_fmt     <= skid_fmt_q;
            out_illegal <= skid_ill_q;
            state_q     <= S_ONE;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an XLEN=32 and an XLEN=64 instance with hand-computed immediates.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // XLEN=32 instance
  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ill;
  logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc, a_out_imm;
  logic [2:0]  a_out_fmt;

  imm_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_ill)
  );

  // XLEN=64 instance
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ill;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_in_pc, b_out_pc, b_out_imm;
  logic [2:0]  b_out_fmt;

  imm_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_ill)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t va[13];
  vec_t vb[4];

  initial begin
    va[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0}; // addi x1,x0,-1
    va[1]  = '{32'hFFF04083, 64'hFFFFFFFF, 3'd1, 1'b0}; // lbu x1,-1(x0)
    va[2]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0}; // beq x0,x0,-4
    va[3]  = '{32'h01F09093, 64'd31,       3'd6, 1'b0}; // slli x1,x1,31
    va[4]  = '{32'hFE112C23, 64'hFFFFFFF8, 3'd2, 1'b0}; // sw x1,-8(x2)
    va[5]  = '{32'h123450B7, 64'h12345000, 3'd4, 1'b0}; // lui x1,0x12345
    va[6]  = '{32'h001000EF, 64'h00000800, 3'd5, 1'b0}; // jal x1,2048
    va[7]  = '{32'h002081B3, 64'h0,        3'd0, 1'b0}; // add
    va[8]  = '{32'h0000007F, 64'h0,        3'd7, 1'b1}; // unknown opcode
    va[9]  = '{32'h00000010, 64'h0,        3'd7, 1'b1}; // addi with [1:0]=00
    va[10] = '{32'h0000001B, 64'h0,        3'd7, 1'b1}; // OP-IMM-32 on RV32
    va[11] = '{32'hFFF03093, 64'hFFFFFFFF, 3'd1, 1'b0}; // sltiu x1,x0,-1
    va[12] = '{32'h00000073, 64'h0,        3'd1, 1'b0}; // ecall
    vb[0]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui x1,0x80000
    vb[1]  = '{32'h43F0D093, 64'd63,               3'd6, 1'b0}; // srai x1,x1,63
    vb[2]  = '{32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // addiw x1,x1,-1
    vb[3]  = '{32'h01F0909B, 64'd31,               3'd6, 1'b0}; // slliw x1,x1,31
  end

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    a_in_instr = '0; a_in_pc = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_instr = '0; b_in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_imm",   a_out_imm,   0);
    chk("rst_out_fmt",   a_out_fmt,   0);
    chk("rst_out_ill",   a_out_ill,   0);
    chk("rst_in_ready",  a_in_ready,  0);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // decode vectors, full throughput
    for (int i = 0; i < 13; i++) begin
      a_in_valid = 1'b1; a_in_instr = va[i].instr; a_in_pc = 32'h100 + 32'(i * 4);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d_imm", i),   a_out_imm,   va[i].imm);
      chk($sformatf("v%0d_fmt", i),   a_out_fmt,   va[i].fmt);
      chk($sformatf("v%0d_ill", i),   a_out_ill,   va[i].ill);
      chk($sformatf("v%0d_pc", i),    a_out_pc,    32'h100 + 32'(i * 4));
    end
    @(posedge clk); #1;
    chk("drain_empty", a_out_valid, 0);

    // backpressure: three entries against a stalled consumer
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h00000013; a_in_pc = 32'h0;
    @(posedge clk); #1;
    chk("bp_valid", a_out_valid, 1);
    chk("bp_ready_one", a_in_ready, 1);
    a_in_pc = 32'h4;
    @(posedge clk); #1;
    chk("bp_ready_two", a_in_ready, 0);
    chk("bp_pc_hold1", a_out_pc, 32'h0);
    a_in_pc = 32'h8;
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_pc_hold", a_out_pc, 32'h0);
      chk("bp_ready_stall", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_pc4", a_out_pc, 32'h4);
    chk("bp_ready_after_pop", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("bp_pc8", a_out_pc, 32'h8);
    chk("bp_pc8_valid", a_out_valid, 1);
    @(posedge clk); #1;
    chk("bp_drained", a_out_valid, 0);

    // flush while two entries are held and a third is offered
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_pc = 32'h10;
    @(posedge clk); #1;
    a_in_pc = 32'h14;
    @(posedge clk); #1;
    a_in_pc = 32'h18; a_flush = 1'b1;
    #1;
    chk("flush_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1;
    chk("flush_out_valid", a_out_valid, 0);
    chk("flush_ready_after", a_in_ready, 1);
    @(posedge clk); #1;
    chk("flush_not_accepted", a_out_valid, 0);

    // RV64 vectors
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_in_instr = vb[i].instr; b_in_pc = 64'h8000_0000_0000 + 64'(i * 4);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk($sformatf("b%0d_valid", i), b_out_valid, 1);
      chk($sformatf("b%0d_imm", i),   b_out_imm,   vb[i].imm);
      chk($sformatf("b%0d_fmt", i),   b_out_fmt,   vb[i].fmt);
      chk($sformatf("b%0d_ill", i),   b_out_ill,   vb[i].ill);
    end

    // async reset in the middle of a cycle clears the held entry at once
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_instr = 32'h800000B7;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_hold_valid", b_out_valid, 1);
    #2;
    b_rst = 1'b1;
    #1;
    chk("b_arst_valid", b_out_valid, 0);
    chk("b_arst_imm",   b_out_imm,   0);
    chk("b_arst_ready", b_in_ready,  0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    #1;
    chk("b_rst_release_ready", b_in_ready, 1);
    chk("b_rst_release_empty", b_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered immediate-generation pipeline stage between fetch and execute for the pipelined RV core. It accepts an instruction and PC over a valid/ready handshake and extracts the format-correct, sign-extended XLEN-bit immediate. It also emits a format code and an illegal-encoding flag in place of X-propagation. A 2-entry skid buffer keeps full throughput under backpressure, and a synchronous flush supports branch redirects.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN, shamt width is log2(XLEN).
SKID_EN, 1, 1 = 2-entry skid buffer (full throughput); 0 = single register, in_ready = !valid_q || out_ready.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts this cycle
out_instr  out  32  instruction passthrough
out_pc  out  XLEN  PC passthrough
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ILLEGAL
out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11

Behaviour:
- Reset (async, while rst=1): all entry valids 0, all data registers 0; out_valid=0, out_imm=0, out_fmt=0, out_illegal=0; in_ready forced 0.
- After reset release: in_ready=1.
- Latency: an instruction accepted at edge N is presented at out_* from edge N (one cycle after presentation at in_*).
- Handshake:
  - Transfer occurs when valid && ready.
  - Output data is held stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Skid FSM (SKID_EN=1), entry count states:
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO; accept with pop → ONE; pop only → EMPTY.
  - TWO: in_ready=0; pop → ONE; the skid entry moves to the output register.
  - Order is strictly FIFO.
- Flush: at the next edge all entries are invalidated (state EMPTY). An in_valid coincident with flush is not accepted, and in_ready reads 0 that cycle. Flush has priority over pop and accept.
- Decode is combinational before the register, on opcode instr[6:0]:
  - LUI 0110111 / AUIPC 0010111: U; imm = sext({instr[31:12], 12'b0}).
  - JAL 1101111: J; sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - JALR 1100111, LOAD 0000011, MISC-MEM 0001111, SYSTEM 1110011: I; sext(instr[31:20]).
    - All loads, including LBU/LHU, sign-extend the offset.
  - OP-IMM 0010011:
    - funct3 001/101: SHAMT; zero-extended instr[20+:log2(XLEN)].
    - Otherwise I; SLTIU sign-extends.
  - STORE 0100011: S; sext({instr[31:25], instr[11:7]}).
  - BRANCH 1100011: B; sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - OP 0110011: NONE; imm = 0.
  - XLEN=64 only: OP-IMM-32 0011011 is I, or SHAMT with a 5-bit shamt.
  - Anything else, or instr[1:0] != 2'b11: fmt=7, illegal=1, imm=0.
- The illegal flag travels as data and does not stall the stage.
- rst asserted mid-transfer: entries are dropped, with no output glitch beyond the async clear.

Decomposition:
- Shared package riscv_pkg holds:
  - the imm_fmt_e enum (3-bit codes above);
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_OPIMM32, OPC_FENCE, OPC_SYSTEM);
  - funct3 constants for shifts.
- One sub-module: riscv_imm_decode, purely combinational, instr → {imm, fmt, illegal}, parametrised by XLEN.
- The stage instantiates riscv_imm_decode and owns the skid buffer and FSM.

Test Plan:
- XLEN=32, out_ready=1: addi x1,x0,-1 (0xFFF00093) → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1; lbu x1,-1(x0) (0xFFF04083) → out_imm=0xFFFFFFFF, out_fmt=1.
- beq x0,x0,-4 (0xFE000EE3) → out_imm=0xFFFFFFFC, fmt=3; slli x1,x1,31 (0x01F09093) → out_imm=31, fmt=6.
- Backpressure: out_ready=0 for 4 cycles while driving pc 0x0/0x4/0x8 with in_valid=1 → in_ready drops after 2 acceptances; out_pc held at 0x0; on out_ready=1, pc 0x0, 0x4, 0x8 emerge in order with no loss or duplication.
- Flush in state TWO with in_valid=1 the same cycle → next cycle out_valid=0 and the incoming instruction is not accepted; the following cycle in_ready=1.
- Illegal 0x0000007F → out_illegal=1, out_fmt=7, out_imm=0; 0x00000013 with in_instr[1:0] forced to 2'b00 → illegal=1.
- XLEN=64: lui x1,0x80000 (0x800000B7) → out_imm=0xFFFFFFFF80000000; srai x1,x1,63 (0x43F0D093) → out_imm=63, fmt=6; async rst pulse mid-stream → out_valid=0 immediately.
